// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n: serial shift-add multiplier, WIDTH-bit signed operand in B
// times WIDTH-bit operand S, 2*WIDTH-bit product left in {A,B} with sign bit X.
// Optional build macro SEQMULT_UNSIGNED_MODE_EN adds a Signed_Mode input that
// selects unsigned operation when low (sampled once, in CLEAR).
//
// Handshake: Run and ClearA_LoadB are active-low button levels. A low Run in
// IDLE starts exactly one operation; the FSM parks in DONE until Run is seen
// high again, so a held button never launches a second multiplication.
// Busy/Done are registered from the next state, so they track the state the
// FSM is entering on each edge.
module seq_multiplier_n #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] S,
`ifdef SEQMULT_UNSIGNED_MODE_EN
  input  logic             Signed_Mode,
`endif
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             x_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_inc;
  logic             busy_q;
  logic             done_q;
  logic             busy_d;
  logic             done_d;
  logic             signed_op;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   sum;

  assign cnt_inc = cnt_q + 1'b1;

`ifdef SEQMULT_UNSIGNED_MODE_EN
  logic mode_q;

  // Operation mode is latched in CLEAR and held for the whole multiplication.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      mode_q <= 1'b1;
    end else if (state_q == ST_CLEAR) begin
      mode_q <= Signed_Mode;
    end
  end

  assign signed_op = mode_q;
`else
  assign signed_op = 1'b1;
`endif

  // State register; reset aborts any operation in progress.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; load has priority over Run in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ClearA_LoadB && !Run) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_ADD;
      ST_ADD:   state_d = ST_SHIFT;
      ST_SHIFT: state_d = (cnt_inc == CW'(WIDTH)) ? ST_DONE : ST_ADD;
      ST_DONE:  if (Run) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state being entered.
  always_comb begin
    busy_d = (state_d == ST_CLEAR) || (state_d == ST_ADD) || (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // Status output registers.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  // Partial-product add; the last step subtracts because B's MSB carries
  // negative weight in two's complement.
  always_comb begin
    a_ext = signed_op ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    s_ext = signed_op ? {S[WIDTH-1], S} : {1'b0, S};
    if (!b_q[0]) begin
      sum = a_ext;
    end else if (signed_op && (cnt_q == CW'(WIDTH - 1))) begin
      sum = a_ext - s_ext;
    end else begin
      sum = a_ext + s_ext;
    end
  end

  // Datapath registers A, B, X and the bit counter.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      a_q   <= '0;
      b_q   <= '0;
      x_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!ClearA_LoadB) begin
            b_q <= S;
            a_q <= '0;
            x_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          a_q   <= '0;
          x_q   <= 1'b0;
          cnt_q <= '0;
        end
        ST_ADD: begin
          a_q <= sum[WIDTH-1:0];
          x_q <= sum[WIDTH];
        end
        ST_SHIFT: begin
          a_q   <= {x_q, a_q[WIDTH-1:1]};
          b_q   <= {a_q[0], b_q[WIDTH-1:1]};
          x_q   <= signed_op ? x_q : 1'b0;
          cnt_q <= cnt_inc;
        end
        default: ;
      endcase
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign X    = x_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_seq_multiplier_n.sv
// tb_seq_multiplier_n: directed and random checks of seq_multiplier_n at
// WIDTH=8 and WIDTH=16 against an arithmetic product model.
module tb_seq_multiplier_n;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        clab8, run8, x8, busy8, done8;
  logic [7:0]  s8, a8, b8;
  logic        clab16, run16, x16, busy16, done16;
  logic [15:0] s16, a16, b16;
  logic        sm_sig;

  seq_multiplier_n #(.WIDTH(8)) dut8 (
    .Clk(clk), .Reset(rst_n), .ClearA_LoadB(clab8), .Run(run8), .S(s8),
`ifdef SEQMULT_UNSIGNED_MODE_EN
    .Signed_Mode(sm_sig),
`endif
    .Aval(a8), .Bval(b8), .X(x8), .Busy(busy8), .Done(done8)
  );

  seq_multiplier_n #(.WIDTH(16)) dut16 (
    .Clk(clk), .Reset(rst_n), .ClearA_LoadB(clab16), .Run(run16), .S(s16),
`ifdef SEQMULT_UNSIGNED_MODE_EN
    .Signed_Mode(sm_sig),
`endif
    .Aval(a16), .Bval(b16), .X(x16), .Busy(busy16), .Done(done16)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [64:0] exp_q[$];
  logic [31:0] bm8, bm16;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer multiply of the operands, split into {X,A,B}.
  function automatic logic [64:0] model(input int w, input logic [31:0] b,
                                        input logic [31:0] s, input logic sgn);
    longint mask, bv, sv, p;
    logic [63:0] pu, hi, lo;
    logic xv;
    mask = (longint'(1) << w) - 1;
    bv = longint'(b) & mask;
    sv = longint'(s) & mask;
    if (sgn) begin
      if (bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
      if (sv >= (longint'(1) << (w - 1))) sv = sv - (longint'(1) << w);
    end
    p  = bv * sv;
    pu = p;
    lo = pu & mask;
    hi = (pu >> w) & mask;
    xv = sgn ? pu[2*w-1] : 1'b0;
    return {xv, hi[31:0], lo[31:0]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int w, input logic cl, input logic rn, input logic [31:0] s);
    if (w == 8) begin
      clab8 = cl; run8 = rn; s8 = s[7:0];
    end else begin
      clab16 = cl; run16 = rn; s16 = s[15:0];
    end
  endtask

  task automatic get_out(input int w, output logic [31:0] a, output logic [31:0] b,
                         output logic x, output logic bsy, output logic dn);
    if (w == 8) begin
      a = {24'd0, a8}; b = {24'd0, b8}; x = x8; bsy = busy8; dn = done8;
    end else begin
      a = {16'd0, a16}; b = {16'd0, b16}; x = x16; bsy = busy16; dn = done16;
    end
  endtask

  task automatic load(input int w, input logic [31:0] b);
    logic [31:0] a, bo;
    logic x, bsy, dn;
    set_in(w, 1'b0, 1'b1, b);
    tick();
    get_out(w, a, bo, x, bsy, dn);
    chk($sformatf("load%0d_b", w), bo, b);
    chk($sformatf("load%0d_a", w), a, 0);
    chk($sformatf("load%0d_busy", w), bsy, 0);
    set_in(w, 1'b1, 1'b1, b);
    if (w == 8) bm8 = b; else bm16 = b;
  endtask

  // Press Run (edge 0) and follow the operation through DONE and release.
  task automatic run_mul(input int w, input logic [31:0] s, input logic sm);
    logic [31:0] a, bo, bcur;
    logic [64:0] e;
    logic x, bsy, dn, sgn;
`ifdef SEQMULT_UNSIGNED_MODE_EN
    sgn = sm;
`else
    sgn = 1'b1;
`endif
    bcur = (w == 8) ? bm8 : bm16;
    exp_q.push_back(model(w, bcur, s, sgn));
    sm_sig = sm;
    set_in(w, 1'b1, 1'b0, s);
    tick();                                   // edge 0
    tick();                                   // edge 1
    get_out(w, a, bo, x, bsy, dn);
    chk($sformatf("w%0d_busy_e1", w), bsy, 1);
    chk($sformatf("w%0d_done_e1", w), dn, 0);
    for (int i = 2; i <= 2 * w; i++) tick();
    get_out(w, a, bo, x, bsy, dn);
    chk($sformatf("w%0d_busy_last", w), bsy, 1);
    chk($sformatf("w%0d_done_early", w), dn, 0);
    tick();                                   // edge 2*w+1
    get_out(w, a, bo, x, bsy, dn);
    e = exp_q.pop_front();
    chk($sformatf("w%0d_done", w), dn, 1);
    chk($sformatf("w%0d_busy_off", w), bsy, 0);
    chk($sformatf("w%0d_a b=%0h s=%0h", w, bcur, s), a, e[63:32]);
    chk($sformatf("w%0d_b b=%0h s=%0h", w, bcur, s), bo, e[31:0]);
    chk($sformatf("w%0d_x b=%0h s=%0h", w, bcur, s), x, e[64]);
    // Held Run and a load press in DONE must change nothing.
    set_in(w, 1'b0, 1'b0, ~s);
    tick();
    tick();
    get_out(w, a, bo, x, bsy, dn);
    chk($sformatf("w%0d_hold_done", w), dn, 1);
    chk($sformatf("w%0d_hold_b", w), bo, e[31:0]);
    chk($sformatf("w%0d_hold_a", w), a, e[63:32]);
    set_in(w, 1'b1, 1'b1, s);
    tick();
    get_out(w, a, bo, x, bsy, dn);
    chk($sformatf("w%0d_release_done", w), dn, 0);
    chk($sformatf("w%0d_release_b", w), bo, e[31:0]);
    if (w == 8) bm8 = e[31:0]; else bm16 = e[31:0];
  endtask

  task automatic chk_reset(input int w);
    logic [31:0] a, bo;
    logic x, bsy, dn;
    get_out(w, a, bo, x, bsy, dn);
    chk($sformatf("rst%0d_a", w), a, 0);
    chk($sformatf("rst%0d_b", w), bo, 0);
    chk($sformatf("rst%0d_x", w), x, 0);
    chk($sformatf("rst%0d_busy", w), bsy, 0);
    chk($sformatf("rst%0d_done", w), dn, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rb, rs, a, bo;
    logic x, bsy, dn;
    rst_n = 1'b0;
    sm_sig = 1'b1;
    set_in(8, 1'b1, 1'b1, 0);
    set_in(16, 1'b1, 1'b1, 0);
    bm8 = 0;
    bm16 = 0;
    tick();
    tick();
    chk_reset(8);
    chk_reset(16);
    rst_n = 1'b1;

    // Basic, then consecutive run reusing the previous low half.
    load(8, 32'h07); run_mul(8, 32'h05, 1'b1);
    run_mul(8, 32'h02, 1'b1);
    load(8, 32'h05); run_mul(8, 32'hFD, 1'b1);
    load(8, 32'h80); run_mul(8, 32'h80, 1'b1);
    load(8, 32'h7F); run_mul(8, 32'h80, 1'b1);
    load(8, 32'h80); run_mul(8, 32'h7F, 1'b1);
    load(8, 32'h00); run_mul(8, 32'hFF, 1'b1);
    load(8, 32'hFF); run_mul(8, 32'h00, 1'b1);
    load(8, 32'hFF); run_mul(8, 32'hFF, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rb = $urandom_range(0, 255);
      rs = $urandom_range(0, 255);
      load(8, rb);
      run_mul(8, rs, 1'b1);
    end

    // Reset sampled on the 6th edge of a run aborts it.
    load(8, 32'h5A);
    set_in(8, 1'b1, 1'b0, 32'h33);
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    chk_reset(8);
    rst_n = 1'b1;
    set_in(8, 1'b1, 1'b1, 0);
    bm8 = 0;
    bm16 = 0;
    tick();
    chk_reset(8);

    // Load and Run together: load wins, multiply starts next cycle.
    set_in(8, 1'b0, 1'b0, 32'h0B);
    tick();
    get_out(8, a, bo, x, bsy, dn);
    chk("both_b", bo, 32'h0B);
    chk("both_busy", bsy, 0);
    bm8 = 32'h0B;
    run_mul(8, 32'hF9, 1'b1);

    // WIDTH=16.
    load(16, 32'h7FFF); run_mul(16, 32'h7FFF, 1'b1);
    load(16, 32'h8000); run_mul(16, 32'hFFFF, 1'b1);
    load(16, 32'h8000); run_mul(16, 32'h8000, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rb = $urandom_range(0, 65535);
      rs = $urandom_range(0, 65535);
      load(16, rb);
      run_mul(16, rs, 1'b1);
    end

`ifdef SEQMULT_UNSIGNED_MODE_EN
    load(8, 32'hFF); run_mul(8, 32'hFF, 1'b0);
    load(8, 32'hFF); run_mul(8, 32'hFF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      rb = $urandom_range(0, 255);
      rs = $urandom_range(0, 255);
      load(8, rb);
      run_mul(8, rs, 1'b0);
      rb = $urandom_range(0, 65535);
      rs = $urandom_range(0, 65535);
      load(16, rb);
      run_mul(16, rs, 1'b0);
    end
`endif

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
